multiplexor_n_reg: RTL
======================

Name: multiplexor_n_reg

Overview:
- Parametrised N-channel registered multiplexer. It is the next generation of the team's 2:1/4:1 combinational data muxes.
- Selects one of CANALES input channels, either by explicit select or by round-robin arbitration. The selected word is captured into an output register.
- Valid/ready handshake on every input and on the output, so it can sit between pipeline stages of the datapath (operand and bus-master selection).

Parameters:
- BITS, 32, data width per channel.
- CANALES, 4, number of input channels (>=2).
- SELW, $clog2(CANALES), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- datoIn  input  CANALES*BITS  packed channel data; channel i = datoIn[i*BITS +: BITS].
- validIn  input  CANALES  channel i holds a valid word.
- readyIn  output  CANALES  one-hot; channel i word consumed this cycle.
- modo  input  1  0 = explicit select, 1 = round-robin.
- selDato  input  SELW  channel index used when modo=0.
- datoOutput  output  BITS  registered selected word.
- validOut  output  1  datoOutput valid.
- readyOut  input  1  downstream accepts datoOutput.
- canalOut  output  SELW  index of the channel that produced datoOutput.

Behaviour:
- Reset (rst_n low, asynchronous): datoOutput=0, validOut=0, canalOut=0, round-robin pointer ptr=0. readyIn=0 while in reset.
- Load condition: acc = !validOut || readyOut. The register accepts a new word only when acc=1.
- Grant generation is combinational from the current inputs and ptr.
  - modo=0: grant = selDato if selDato<CANALES and validIn[selDato]; otherwise no grant.
  - modo=1: search ptr, ptr+1, ..., ptr+CANALES-1 (mod CANALES); grant = first index with validIn set; no grant if validIn=0.
- Transfer occurs when a grant exists and acc=1. On a transfer:
  - readyIn[grant]=1; all other readyIn bits are 0.
  - Next edge: datoOutput<=word of grant, canalOut<=grant, validOut<=1.
  - If modo=1: ptr<=(grant+1) mod CANALES, wrapping from CANALES-1 to 0.
- No transfer and readyOut=1: validOut<=0. datoOutput and canalOut hold their last values.
- No transfer and readyOut=0: all outputs hold.
- Stall: validOut=1 and readyOut=0 → acc=0, all readyIn=0, output stable every cycle until accepted.
- Simultaneous accept and refill: validOut=1, readyOut=1 and a grant exists → the old word leaves and the new word loads on the same edge. Full throughput is 1 word/cycle.
- Latency: input word appears on datoOutput 1 cycle after its transfer cycle.
- ptr does not change in modo=0. It also does not change on cycles without a transfer.
- Changing modo or selDato mid-stall does not affect the held output; it applies to the next grant only.
- Out-of-range selDato (CANALES not a power of 2) produces no transfer and no error.
- rst_n asserted mid-transfer: output register and ptr clear immediately; the in-flight word is dropped.

Optional Feature:
- Macro: MULTIPLEXOR_N_LOCK_EN.
- Defined: adds port lockIn (input, 1).
  - With modo=1, lockIn=1 and validOut=1, the arbiter grants only channel canalOut; other channels are not granted even if valid. This gives burst ownership.
  - ptr is not updated while locked.
  - lockIn has no effect in modo=0.
- Not defined: port absent; behaviour identical to lockIn=0.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with traffic present → validOut=0, datoOutput=0, canalOut=0 asynchronously; first RR grant after release goes to channel 0.
- Explicit select: modo=0, selDato=2, datoIn ch2=32'hCAFE_0002, validIn=4'b1111, readyOut=1 → readyIn=4'b0100; next cycle datoOutput=32'hCAFE_0002, canalOut=2, validOut=1.
- Round-robin fairness: modo=1, validIn=4'b1111 held, readyOut=1 for 8 cycles → canalOut sequence 0,1,2,3,0,1,2,3. Then validIn=4'b1001 → sequence 0,3,0,3.
- Backpressure: validOut=1, readyOut=0 for 5 cycles with inputs changing → readyIn=0 and datoOutput/canalOut unchanged throughout. readyOut=1 → same-edge refill with the next granted word.
- Empty/drain: validIn=0, readyOut=1 after one word → validOut drops next cycle and ptr is unchanged. modo=0 with selDato pointing at an invalid channel → no readyIn asserted.
- Lock (MULTIPLEXOR_N_LOCK_EN): modo=1, validIn=4'b1111, first grant ch1, lockIn=1 for 3 cycles → canalOut=1,1,1. lockIn=0 → next grant ch2.

Source files
------------

// File: rtl/multiplexor_n_reg.sv
// Registered N-channel mux with explicit-select or round-robin grant and valid/ready on every side.
// Define MULTIPLEXOR_N_LOCK_EN to add lockIn (burst ownership of the current channel in round-robin mode).
module multiplexor_n_reg #(
   parameter int BITS    = 32,
   parameter int CANALES = 4,
   parameter int SELW    = $clog2(CANALES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CANALES*BITS-1:0] datoIn,
   input  logic [CANALES-1:0]      validIn,
   output logic [CANALES-1:0]      readyIn,
   input  logic                    modo,
   input  logic [SELW-1:0]         selDato,
`ifdef MULTIPLEXOR_N_LOCK_EN
   input  logic                    lockIn,
`endif
   output logic [BITS-1:0]         datoOutput,
   output logic                    validOut,
   input  logic                    readyOut,
   output logic [SELW-1:0]         canalOut
);

   localparam int NPOW = 1 << SELW;

   // channels padded to a power of two; padding never holds a valid word
   logic [BITS-1:0] canal [NPOW];
   logic [NPOW-1:0] vext;
   logic [NPOW-1:0] oh;
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] gnt;
   logic [SELW-1:0] nxt;
   logic            gntv;
   logic            acc;
   logic            xfer;
   logic            locked;

   for (genvar g = 0; g < NPOW; g++) begin : g_canal
      if (g < CANALES) begin : g_real
         assign canal[g] = datoIn[g*BITS +: BITS];
      end else begin : g_pad
         assign canal[g] = '0;
      end
   end

   assign vext = NPOW'(validIn);

`ifdef MULTIPLEXOR_N_LOCK_EN
   assign locked = modo && lockIn && validOut;
`else
   assign locked = 1'b0;
`endif

   always_comb begin : arb
      logic [SELW:0] sum;
      gnt  = '0;
      gntv = 1'b0;
      sum  = '0;
      if (!modo) begin
         gnt  = selDato;
         gntv = vext[selDato];
      end else if (locked) begin
         gnt  = canalOut;
         gntv = vext[canalOut];
      end else begin
         // scan backwards so the entry closest to ptr wins
         for (int k = CANALES - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(CANALES))
               sum = sum - (SELW+1)'(CANALES);
            if (vext[sum[SELW-1:0]]) begin
               gnt  = sum[SELW-1:0];
               gntv = 1'b1;
            end
         end
      end
   end

   assign acc  = !validOut || readyOut;
   assign xfer = gntv && acc && rst_n;
   assign oh   = NPOW'(1) << gnt;
   assign readyIn = xfer ? oh[CANALES-1:0] : '0;
   assign nxt  = (gnt == SELW'(CANALES - 1)) ? '0 : gnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         datoOutput <= '0;
         validOut   <= 1'b0;
         canalOut   <= '0;
         ptr        <= '0;
      end else if (xfer) begin
         datoOutput <= canal[gnt];
         canalOut   <= gnt;
         validOut   <= 1'b1;
         if (modo && !locked)
            ptr <= nxt;
      end else if (readyOut) begin
         validOut <= 1'b0;
      end
   end

endmodule
